// File: rtl/phase_nco.sv
// Phase accumulator NCO producing a wrapped Q3.13 phase in [-pi, +pi) for a sincos stage.
// Optional feature macro: PHASE_NCO_FREQ_RAMP_EN (linear increment ramp instead of wrap-aligned steps).
module phase_nco #(
   parameter int unsigned SAMPLE_DIV     = 1,
   parameter logic [15:0] PHASE_STEP_MAX = 16'd4096,
   parameter logic [15:0] RAMP_STEP      = 16'd1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               phase_clr,
   input  logic [15:0]        freq_word,
   input  logic               freq_word_valid,
   output logic signed [15:0] phase,
   output logic               phase_tvalid,
   output logic               cycle_start,
   output logic [15:0]        active_inc
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [15:0]        DIV_LAST = 16'(SAMPLE_DIV - 1);
   localparam logic signed [17:0] PI_POS   = 18'sd25736;
   localparam logic signed [17:0] TWO_PI   = 18'sd51472;

   state_t             state_r;
   state_t             state_s;
   logic [15:0]        cnt_r;
   logic [15:0]        cnt_s;
   logic signed [15:0] phase_r;
   logic signed [15:0] phase_s;
   logic               tvalid_r;
   logic               tvalid_s;
   logic               cstart_r;
   logic               cstart_s;
   logic [15:0]        active_r;
   logic [15:0]        active_s;
   logic [15:0]        pending_r;
   logic [15:0]        pending_s;
   logic               tick_s;
   logic               wrap_s;
   logic signed [17:0] sum_s;
   logic signed [17:0] wrapped_s;

   function automatic logic [15:0] clamp_step(input logic [15:0] word);
      logic [15:0] res;
      if (word > PHASE_STEP_MAX) begin
         res = PHASE_STEP_MAX;
      end else begin
         res = word;
      end
      return res;
   endfunction

`ifdef PHASE_NCO_FREQ_RAMP_EN
   // One ramp step from cur toward tgt, landing exactly on tgt rather than overshooting.
   function automatic logic [15:0] ramp_toward(input logic [15:0] cur, input logic [15:0] tgt);
      logic [16:0] up;
      logic [15:0] res;
      up = {1'b0, cur} + {1'b0, RAMP_STEP};
      if (cur < tgt) begin
         if (up >= {1'b0, tgt}) begin
            res = tgt;
         end else begin
            res = up[15:0];
         end
      end else if (cur > tgt) begin
         if ((cur - tgt) <= RAMP_STEP) begin
            res = tgt;
         end else begin
            res = cur - RAMP_STEP;
         end
      end else begin
         res = cur;
      end
      return res;
   endfunction
`else
   logic pend_valid_r;
   logic pend_valid_s;
   logic apply_s;
`endif

   // Run/idle state register: follows enable one clock late.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = IDLE;
      case (state_r)
         IDLE:    state_s = enable ? RUN : IDLE;
         RUN:     state_s = enable ? RUN : IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Sample divider, phase accumulation with modular wrap, and phase_clr override.
   always_comb begin
      tick_s    = (state_r == RUN) && (cnt_r == DIV_LAST);
      sum_s     = phase_r + $signed({2'b00, active_r});
      wrapped_s = sum_s - TWO_PI;
      wrap_s    = tick_s && !phase_clr && (sum_s >= PI_POS);
      cnt_s     = cnt_r;
      phase_s   = phase_r;
      tvalid_s  = 1'b0;
      cstart_s  = 1'b0;
      if (phase_clr) begin
         cnt_s    = 16'd0;
         phase_s  = 16'sd0;
         cstart_s = 1'b1;
      end else if (tick_s) begin
         cnt_s    = 16'd0;
         tvalid_s = 1'b1;
         if (sum_s >= PI_POS) begin
            phase_s  = $signed(wrapped_s[15:0]);
            cstart_s = 1'b1;
         end else begin
            phase_s  = $signed(sum_s[15:0]);
            cstart_s = 1'b0;
         end
      end else if (state_r == RUN) begin
         cnt_s = cnt_r + 16'd1;
      end else begin
         cnt_s = 16'd0;
      end
   end

   // Increment management: pending request and the increment actually in use.
   always_comb begin
      pending_s = freq_word_valid ? clamp_step(freq_word) : pending_r;
`ifdef PHASE_NCO_FREQ_RAMP_EN
      if (tick_s && !phase_clr) begin
         active_s = ramp_toward(active_r, pending_r);
      end else begin
         active_s = active_r;
      end
`else
      // New increments land only at a wrap so the frequency step starts on a cycle boundary.
      apply_s  = pend_valid_r && ((active_r == 16'd0) || wrap_s);
      active_s = apply_s ? pending_r : active_r;
      if (freq_word_valid) begin
         pend_valid_s = 1'b1;
      end else if (apply_s) begin
         pend_valid_s = 1'b0;
      end else begin
         pend_valid_s = pend_valid_r;
      end
`endif
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r     <= 16'd0;
         phase_r   <= 16'sd0;
         tvalid_r  <= 1'b0;
         cstart_r  <= 1'b0;
         active_r  <= 16'd0;
         pending_r <= 16'd0;
      end else begin
         cnt_r     <= cnt_s;
         phase_r   <= phase_s;
         tvalid_r  <= tvalid_s;
         cstart_r  <= cstart_s;
         active_r  <= active_s;
         pending_r <= pending_s;
      end
   end

`ifndef PHASE_NCO_FREQ_RAMP_EN
   // Pending-request flag, cleared when the request is applied or on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid_r <= 1'b0;
      end else begin
         pend_valid_r <= pend_valid_s;
      end
   end
`endif

   assign phase        = phase_r;
   assign phase_tvalid = tvalid_r;
   assign cycle_start  = cstart_r;
   assign active_inc   = active_r;

endmodule

// File: tb/tb_phase_nco.sv
// Randomized self-checking bench for phase_nco: two instances (SAMPLE_DIV 1 and 4) against a sample-level model.
module tb_phase_nco;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               enable = 1'b0;
   logic               phase_clr = 1'b0;
   logic [15:0]        freq_word = 16'd0;
   logic               freq_word_valid = 1'b0;
   logic signed [15:0] ph [2];
   logic               tv [2];
   logic               cs [2];
   logic [15:0]        act [2];

   int checks = 0;
   int errors = 0;
   int samp_cnt = 0;
   bit started = 1'b0;
   bit lit_on = 1'b0;

   int m_ph [2];
   int m_tv [2];
   int m_cs [2];
   int m_act [2];
   int m_pend [2];
   int m_pv [2];
   int m_cnt [2];
   int m_run [2];
   int div [2] = '{1, 4};

   always #5 clk = ~clk;

   phase_nco #(.SAMPLE_DIV(1), .PHASE_STEP_MAX(16'd4096), .RAMP_STEP(16'd16)) dut1 (
      .clk(clk), .rst(rst), .enable(enable), .phase_clr(phase_clr),
      .freq_word(freq_word), .freq_word_valid(freq_word_valid),
      .phase(ph[0]), .phase_tvalid(tv[0]), .cycle_start(cs[0]), .active_inc(act[0]));

   phase_nco #(.SAMPLE_DIV(4), .PHASE_STEP_MAX(16'd4096), .RAMP_STEP(16'd16)) dut4 (
      .clk(clk), .rst(rst), .enable(enable), .phase_clr(phase_clr),
      .freq_word(freq_word), .freq_word_valid(freq_word_valid),
      .phase(ph[1]), .phase_tvalid(tv[1]), .cycle_start(cs[1]), .active_inc(act[1]));

   task automatic chk(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: one step per clock, written in terms of samples and wraps.
   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (rst) begin
            m_ph[u] = 0; m_tv[u] = 0; m_cs[u] = 0; m_act[u] = 0;
            m_pend[u] = 0; m_pv[u] = 0; m_cnt[u] = 0; m_run[u] = 0;
         end else begin
            int s;
            bit tick;
            bit wrapped;
            tick = (m_run[u] != 0) && (m_cnt[u] == div[u] - 1);
            wrapped = 1'b0;
            m_tv[u] = 0;
            m_cs[u] = 0;
            if (phase_clr) begin
               m_ph[u] = 0; m_cs[u] = 1; m_cnt[u] = 0;
            end else begin
               if (tick) begin
                  s = m_ph[u] + m_act[u];
                  if (s >= 25736) begin
                     s = s - 51472;
                     m_cs[u] = 1;
                     wrapped = 1'b1;
                  end
                  m_ph[u] = s;
                  m_tv[u] = 1;
               end
               m_cnt[u] = (m_run[u] == 0 || tick) ? 0 : m_cnt[u] + 1;
            end
`ifdef PHASE_NCO_FREQ_RAMP_EN
            if (tick && !phase_clr) begin
               if (m_act[u] < m_pend[u])
                  m_act[u] = (m_pend[u] - m_act[u] <= 16) ? m_pend[u] : m_act[u] + 16;
               else if (m_act[u] > m_pend[u])
                  m_act[u] = (m_act[u] - m_pend[u] <= 16) ? m_pend[u] : m_act[u] - 16;
            end
`else
            if (m_pv[u] != 0 && (m_act[u] == 0 || wrapped)) begin
               m_act[u] = m_pend[u];
               m_pv[u] = 0;
            end
`endif
            if (freq_word_valid) begin
               m_pend[u] = (int'(freq_word) > 4096) ? 4096 : int'(freq_word);
               m_pv[u] = 1;
            end
            m_run[u] = enable ? 1 : 0;
         end
      end
      started = 1'b1;
   end

   // Compare process, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         for (int u = 0; u < 2; u++) begin
            chk($sformatf("phase[%0d]", u), int'(ph[u]), m_ph[u]);
            chk($sformatf("tvalid[%0d]", u), int'(tv[u]), m_tv[u]);
            chk($sformatf("cycle_start[%0d]", u), int'(cs[u]), m_cs[u]);
            chk($sformatf("active_inc[%0d]", u), int'(act[u]), m_act[u]);
         end
         if (rst) begin
            samp_cnt = 0;
         end else if (tv[0]) begin
            samp_cnt++;
            if (lit_on) begin
`ifdef PHASE_NCO_FREQ_RAMP_EN
               if (samp_cnt == 15) chk("ramp_tick15", int'(act[0]), 240);
               if (samp_cnt == 16) chk("ramp_tick16", int'(act[0]), 256);
               if (samp_cnt == 30) chk("ramp_hold", int'(act[0]), 256);
`else
               if (samp_cnt == 1) chk("sample1", int'(ph[0]), 256);
               if (samp_cnt == 100) chk("sample100", int'(ph[0]), 25600);
               if (samp_cnt == 101) begin
                  chk("sample101", int'(ph[0]), -25616);
                  chk("sample101_cs", int'(cs[0]), 1);
               end
`endif
            end
         end
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic load(input logic [15:0] w);
      freq_word = w;
      freq_word_valid = 1'b1;
      step(1);
      freq_word_valid = 1'b0;
   endtask

   initial begin
      int frozen;
      step(3);
      chk("reset_phase", int'(ph[0]), 0);
      chk("reset_active", int'(act[0]), 0);
      chk("reset_tvalid", int'(tv[0]), 0);
      rst = 1'b0;
      lit_on = 1'b1;
      load(16'd256);
      step(1);
      chk("first_load_active", int'(act[0]), 256);
      enable = 1'b1;
      step(105);
      chk("sample_count", int'(samp_cnt >= 101), 1);
      lit_on = 1'b0;

      load(16'd300);
      step(250);
      chk("second_load_active", int'(act[0]), 300);

      load(16'd8000);
      step(250);
      chk("clamp_active", int'(act[0]), 4096);

      enable = 1'b0;
      step(3);
      frozen = int'(ph[1]);
      step(10);
      chk("idle_frozen", int'(ph[1]), frozen);
      chk("idle_tvalid", int'(tv[1]), 0);

      enable = 1'b1;
      step(20);
      phase_clr = 1'b1;
      step(1);
      chk("clr_phase", int'(ph[0]), 0);
      chk("clr_cs", int'(cs[0]), 1);
      chk("clr_tvalid", int'(tv[0]), 0);
      phase_clr = 1'b0;
      step(15);
      rst = 1'b1;
      step(1);
      chk("rst_phase", int'(ph[0]), 0);
      chk("rst_active", int'(act[0]), 0);
      chk("rst_tvalid", int'(tv[0]), 0);
      rst = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) enable = ~enable;
         freq_word_valid = ($urandom_range(0, 19) == 0);
         freq_word = 16'($urandom_range(0, 9000));
         phase_clr = ($urandom_range(0, 99) == 0);
         rst = ($urandom_range(0, 499) == 0);
         step(1);
      end
      rst = 1'b0;
      phase_clr = 1'b0;
      freq_word_valid = 1'b0;
      step(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/phase_nco.md
PHASE_NCO -- requirements
Module: phase_nco

Interface
REQ-001 The module SHALL have parameter SAMPLE_DIV, default 1, giving clocks per output phase sample (1..65535).
REQ-002 The module SHALL have parameter PHASE_STEP_MAX, default 16'd4096, giving the maximum phase increment (Q3.13 radians).
REQ-003 The module SHALL have parameter RAMP_STEP, default 16'd1, giving the increment change per sample in ramp mode.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset is synchronous and active-high.
REQ-006 The module SHALL have port enable, input, 1 bit, run/pause control.
REQ-007 The module SHALL have port phase_clr, input, 1 bit, a synchronous phase-to-zero strobe.
REQ-008 The module SHALL have port freq_word, input, 16 bits unsigned, the requested phase increment per sample (Q3.13).
REQ-009 The module SHALL have port freq_word_valid, input, 1 bit, a load strobe for freq_word.
REQ-010 The module SHALL have port phase, output, 16 bits signed Q3.13, the phase in [-pi, +pi), which feeds the sincos stage.
REQ-011 The module SHALL have port phase_tvalid, output, 1 bit, marking phase as a new sample.
REQ-012 The module SHALL have port cycle_start, output, 1 bit, a pulse marking a sample at which the phase wrapped.
REQ-013 The module SHALL have port active_inc, output, 16 bits, the increment currently in use.

Function
REQ-014 The module SHALL use the constants PI_POS = 0x6488 (25736), PI_NEG = 0x9B78 (-25736) and TWO_PI = 51472.
REQ-015 The module SHALL have two states: IDLE (enable=0) and RUN (enable=1). The state follows enable with one clock of delay.
REQ-016 In RUN, a divider counter SHALL count 0..SAMPLE_DIV-1. The tick is at SAMPLE_DIV-1, after which the counter returns to 0.
REQ-017 In IDLE, the counter SHALL be held at 0, phase SHALL hold its value, and phase_tvalid SHALL be 0.
REQ-018 On a tick, the module SHALL compute sum = phase + active_inc at 18-bit signed width.
REQ-019 If sum >= PI_POS, the next phase SHALL be sum - TWO_PI (exact modular wrap, no clamping) and cycle_start SHALL be 1.
REQ-020 If sum < PI_POS, the next phase SHALL be sum and cycle_start SHALL be 0.
REQ-021 phase, phase_tvalid and cycle_start SHALL update in the same clock, one clock after the tick, with phase_tvalid high for exactly one clock.
REQ-022 With SAMPLE_DIV=1, phase_tvalid SHALL therefore be continuously high in RUN.
REQ-023 On freq_word_valid, the module SHALL latch min(freq_word, PHASE_STEP_MAX) into pending_inc; a later strobe overwrites an unapplied one.
REQ-024 pending_inc SHALL be applied to active_inc at a wrap tick, or immediately on the next clock if active_inc == 0.
REQ-025 Increment changes SHALL therefore occur only at cycle boundaries (glitch-free frequency steps).
REQ-026 The increment used for the wrap sample SHALL be the old value; the first sample after the wrap SHALL use the new value.
REQ-027 phase_clr SHALL set phase to 0, the counter to 0, and cycle_start to 1 on the next clock, and SHALL NOT assert phase_tvalid.
REQ-028 phase_clr SHALL take priority over a coincident tick.
REQ-029 Priority SHALL be: rst > phase_clr > tick > hold.

Reset
REQ-030 While rst=1, on each clock the module SHALL set phase=0, phase_tvalid=0, cycle_start=0, active_inc=0, pending_inc=0, counter=0 and state=IDLE.
REQ-031 rst asserted mid-operation SHALL discard any pending increment and any in-progress ramp.

Configuration
REQ-032 The feature SHALL be controlled by macro PHASE_NCO_FREQ_RAMP_EN.
REQ-033 When PHASE_NCO_FREQ_RAMP_EN is defined, active_inc SHALL move toward pending_inc by RAMP_STEP per tick without waiting for a wrap, clamping exactly at pending_inc; REQ-024 does not apply.
REQ-034 When PHASE_NCO_FREQ_RAMP_EN is undefined, the ramp logic SHALL be absent and REQ-024 SHALL govern.

Verification
REQ-035 Reset, freq_word=256 loaded, enable=1, SAMPLE_DIV=1 -> phase = 256, 512, ...; sample 100 = 25600; sample 101 = -25616 with cycle_start=1.
REQ-036 Run at 256, load 300 mid-cycle -> all samples through the wrap use 256; the sample after the wrap = wrapped + 300.
REQ-037 Load freq_word=8000 with PHASE_STEP_MAX=4096 -> active_inc = 4096.
REQ-038 SAMPLE_DIV=4, enable high -> phase_tvalid is a 1-clock pulse every 4 clocks; enable low -> phase frozen and phase_tvalid=0.
REQ-039 rst mid-run, or phase_clr mid-run -> next clock phase=0; rst also gives active_inc=0 and phase_tvalid=0.
REQ-040 With PHASE_NCO_FREQ_RAMP_EN, RAMP_STEP=16, 0 -> 256 requested -> active_inc reaches 256 after exactly 16 ticks, then holds.
